data_mem_ctrl: RTL

DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

---
 rtl/dmem_pkg.sv | 36 +++
 rtl/dmem_lane_align.sv | 46 ++++
 rtl/data_mem_ctrl.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data memory controller.
// Lane widths, access-mode encoding, FSM states and the power-on memory image.
package dmem_pkg;

   localparam int unsigned ByteW    = 8;
   localparam int unsigned HalfW    = 16;
   localparam int unsigned WordW    = 32;
   localparam int unsigned NumLanes = WordW / ByteW;

   typedef enum logic [2:0] {
      DmByte  = 3'b000,
      DmHalf  = 3'b001,
      DmWord  = 3'b010,
      DmByteU = 3'b100,
      DmHalfU = 3'b101
   } dmctrl_e;

   typedef enum logic [1:0] {
      StIdle,
      StWait,
      StResp
   } state_e;

   function automatic logic ctrl_legal(input logic [2:0] ctrl);
      return ctrl inside {DmByte, DmHalf, DmWord, DmByteU, DmHalfU};
   endfunction

   function automatic logic [WordW-1:0] init_word(input logic [31:0] idx);
      case (idx)
         32'd0:   return 32'h0000_0010;
         32'd1:   return 32'hAABB_CCDD;
         default: return '0;
      endcase
   endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane handling: load byte/half select with sign or zero extension,
// store byte enables and store data replicated onto the addressed lanes.
module dmem_lane_align
   import dmem_pkg::*;
(
   input  logic [2:0]          ctrl,
   input  logic [1:0]          offset,
   input  logic [WordW-1:0]    rdata,
   input  logic [WordW-1:0]    wdata,
   output logic [WordW-1:0]    load_data,
   output logic [NumLanes-1:0] byte_en,
   output logic [WordW-1:0]    wdata_lanes
);

   logic [ByteW-1:0] rbyte;
   logic [HalfW-1:0] rhalf;

   always_comb begin
      rbyte       = rdata[{offset, 3'b000} +: ByteW];
      rhalf       = offset[1] ? rdata[WordW-1:HalfW] : rdata[HalfW-1:0];
      load_data   = '0;
      byte_en     = '0;
      wdata_lanes = wdata;
      case (ctrl)
         DmByte, DmByteU: begin
            load_data   = (ctrl == DmByte) ? {{(WordW-ByteW){rbyte[ByteW-1]}}, rbyte}
                                           : {{(WordW-ByteW){1'b0}}, rbyte};
            byte_en     = 4'b0001 << offset;
            wdata_lanes = {NumLanes{wdata[ByteW-1:0]}};
         end
         DmHalf, DmHalfU: begin
            // Half lane comes from offset[1] only; offset[0] is dropped here.
            load_data   = (ctrl == DmHalf) ? {{(WordW-HalfW){rhalf[HalfW-1]}}, rhalf}
                                           : {{(WordW-HalfW){1'b0}}, rhalf};
            byte_en     = offset[1] ? 4'b1100 : 4'b0011;
            wdata_lanes = {2{wdata[HalfW-1:0]}};
         end
         DmWord: begin
            load_data = rdata;
            byte_en   = '1;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/data_mem_ctrl.sv
// Single-outstanding data memory controller with fixed wait states and a held response.
// Define DMEM_MISALIGN_CHECK_EN to fault misaligned half/word accesses instead of ignoring low bits.
module data_mem_ctrl
   import dmem_pkg::*;
#(
   parameter int unsigned DEPTH       = 256,
   parameter int unsigned WAIT_STATES = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        Req,
   output logic        Ready,
   input  logic [31:0] Address,
   input  logic [31:0] DataWr,
   input  logic        DMWr,
   input  logic [2:0]  DMCtrl,
   output logic        RspValid,
   input  logic        RspReady,
   output logic [31:0] DataRd,
   output logic        Err
);

   localparam int unsigned IdxW = $clog2(DEPTH);

   state_e              state_q;
   logic [3:0]          cnt_q;
   logic [WordW-1:0]    addr_q, wdata_q, rdata_q;
   logic [2:0]          ctrl_q;
   logic                wr_q, ready_q, rsp_valid_q, err_q;

   logic                idle, accept, enter_resp;
   logic                addr_err, ctrl_err, misalign_err, req_err;
   logic [WordW-1:0]    cur_addr, cur_wdata;
   logic [2:0]          cur_ctrl;
   logic                cur_wr;
   logic [IdxW-1:0]     idx;
   logic [WordW-1:0]    mem_q [DEPTH];
   logic [WordW-1:0]    rd_word, load_data, wdata_lanes, merged, rsp_data;
   logic [NumLanes-1:0] byte_en;

   assign idle   = (state_q == StIdle);
   assign accept = idle && Req && ready_q;

   // With zero wait states the response is built from the live inputs on the acceptance edge.
   assign cur_addr  = idle ? Address : addr_q;
   assign cur_wdata = idle ? DataWr  : wdata_q;
   assign cur_wr    = idle ? DMWr    : wr_q;
   assign cur_ctrl  = idle ? DMCtrl  : ctrl_q;

   assign enter_resp = (accept && (WAIT_STATES == 0)) || ((state_q == StWait) && (cnt_q == 4'd1));

   assign idx      = cur_addr[IdxW+1:2];
   assign addr_err = |(cur_addr >> (IdxW + 2));
   assign ctrl_err = !ctrl_legal(cur_ctrl);
`ifdef DMEM_MISALIGN_CHECK_EN
   assign misalign_err = (((cur_ctrl == DmHalf) || (cur_ctrl == DmHalfU)) && cur_addr[0])
                      || ((cur_ctrl == DmWord) && (cur_addr[1:0] != 2'b00));
`else
   assign misalign_err = 1'b0;
`endif
   assign req_err = addr_err || ctrl_err || misalign_err;

   // Storage holds the XOR against the power-on image, so an all-zero array reads as that image.
   assign rd_word = mem_q[idx] ^ init_word(WordW'(idx));

   dmem_lane_align u_lane_align (
      .ctrl        (cur_ctrl),
      .offset      (cur_addr[1:0]),
      .rdata       (rd_word),
      .wdata       (cur_wdata),
      .load_data   (load_data),
      .byte_en     (byte_en),
      .wdata_lanes (wdata_lanes)
   );

   always_comb begin
      merged = rd_word;
      for (int i = 0; i < NumLanes; i++) begin
         if (byte_en[i]) merged[i*ByteW +: ByteW] = wdata_lanes[i*ByteW +: ByteW];
      end
   end

   assign rsp_data = (cur_wr || req_err) ? '0 : load_data;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         addr_q      <= '0;
         wdata_q     <= '0;
         wr_q        <= 1'b0;
         ctrl_q      <= '0;
         ready_q     <= 1'b1;
         rsp_valid_q <= 1'b0;
         err_q       <= 1'b0;
         rdata_q     <= '0;
      end else begin
         case (state_q)
            StIdle: begin
               if (accept) begin
                  addr_q  <= Address;
                  wdata_q <= DataWr;
                  wr_q    <= DMWr;
                  ctrl_q  <= DMCtrl;
                  ready_q <= 1'b0;
                  if (WAIT_STATES == 0) begin
                     state_q <= StResp;
                  end else begin
                     state_q <= StWait;
                     cnt_q   <= 4'(WAIT_STATES);
                  end
               end
            end
            StWait: begin
               cnt_q <= cnt_q - 4'd1;
               if (cnt_q == 4'd1) state_q <= StResp;
            end
            StResp: begin
               if (RspReady) begin
                  state_q     <= StIdle;
                  ready_q     <= 1'b1;
                  rsp_valid_q <= 1'b0;
                  err_q       <= 1'b0;
                  rdata_q     <= '0;
               end
            end
            default: state_q <= StIdle;
         endcase
         if (enter_resp) begin
            rsp_valid_q <= 1'b1;
            err_q       <= req_err;
            rdata_q     <= rsp_data;
            if (cur_wr && !req_err) mem_q[idx] <= merged ^ init_word(WordW'(idx));
         end
      end
   end

   assign Ready    = ready_q;
   assign RspValid = rsp_valid_q;
   assign Err      = err_q;
   assign DataRd   = rdata_q;

endmodule
